// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the binary-to-BCD front end of the seven-segment display path.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // Non-decimal code; the downstream segment decoder blanks it.
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more before it is shifted.
module bcd_adjust (
  input  logic [3:0] x,
  output logic [3:0] y
);

  always_comb begin
    y = (x >= 4'd5) ? (x + 4'd3) : x;
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with registered digit outputs
// that update only once a conversion has completed.
module bin_to_bcd_converter
  import seven_seg_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic [3:0]           ones,
  output logic [3:0]           tens,
  output logic [3:0]           hundreds,
  output logic [3:0]           thousands,
  output logic                 overflow,
  output logic                 done
);

  localparam int unsigned SR_W    = DIGITS * 4 + BIN_WIDTH;
  localparam int unsigned CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  bcd_state_t state_q, state_d;
  logic [SR_W-1:0]               sr_q, sr_d, sr_adj;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          ovf_pend_q, ovf_pend_d;
  logic [DIGITS-1:0][3:0]        dig_q, dig_d;
  logic                          overflow_q, overflow_d;
  logic                          done_q, done_d;

  // Only the BCD field is corrected; the binary field passes through untouched.
  assign sr_adj[BIN_WIDTH-1:0] = sr_q[BIN_WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adjust u_adj (
      .x (sr_q  [BIN_WIDTH + 4*g +: 4]),
      .y (sr_adj[BIN_WIDTH + 4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    dig_d      = dig_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d       = {{(DIGITS*4){1'b0}}, bin};
          cnt_d      = '0;
          ovf_pend_d = (32'(bin) > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          dig_d[i] = ovf_pend_q ? BCD_BLANK : sr_q[BIN_WIDTH + 4*i +: 4];
        end
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      dig_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      dig_q      <= dig_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ones      = dig_q[0];
  assign tens      = dig_q[1];
  assign hundreds  = dig_q[2];
  assign thousands = dig_q[3];
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: fixed vectors, corner sequences and random values
// checked against a decimal-arithmetic reference.
module tb_bin_to_bcd_converter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic        overflow;
  logic        done;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_converter #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] b;
    logic [15:0] dg;
    logic        ov;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] ref_model(input int unsigned v);
    if (v > 9999) return {1'b1, 16'hFFFF};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] digits_now();
    return {thousands, hundreds, tens, ones};
  endfunction

  task automatic do_conv(input logic [13:0] v, output logic [15:0] dg, output logic ov);
    int lat;
    lat = -1;
    @(negedge clk);
    chk("ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    bin      = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin      = 14'($urandom);
    chk("done_one_cycle", int'(done), 0);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    dg = digits_now();
    ov = overflow;
    if (lat < 0) chk("done_timeout", 0, 1);
    else chk("latency", lat, 15);
  endtask

  initial begin
    logic [15:0] dg;
    logic        ov;
    logic [16:0] r;
    logic [15:0] prior;
    int          dcount;
    int          lat;

    vt[0] = '{14'd1234,  16'h1234, 1'b0};
    vt[1] = '{14'd0,     16'h0000, 1'b0};
    vt[2] = '{14'd9999,  16'h9999, 1'b0};
    vt[3] = '{14'd10000, 16'hFFFF, 1'b1};
    vt[4] = '{14'd42,    16'h0042, 1'b0};
    vt[5] = '{14'd16383, 16'hFFFF, 1'b1};
    vt[6] = '{14'd5,     16'h0005, 1'b0};
    vt[7] = '{14'd8765,  16'h8765, 1'b0};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    bin      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_digits", int'(digits_now()), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ready", int'(in_ready), 1);

    // Table vectors run back-to-back: each accept lands in the first IDLE cycle after done.
    for (int i = 0; i < 8; i++) begin
      do_conv(vt[i].b, dg, ov);
      chk("vec_digits", int'(dg), int'(vt[i].dg));
      chk("vec_overflow", int'(ov), int'(vt[i].ov));
    end

    // in_valid held with changing bin while busy: only the first value converts.
    prior = digits_now();
    @(negedge clk);
    in_valid = 1'b1;
    bin      = 14'd321;
    @(posedge clk);
    #1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      bin = 14'($urandom_range(0, 16383));
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      chk("busy_ready_low", int'(in_ready), 0);
      chk("busy_digits_hold", int'(digits_now()), int'(prior));
    end
    in_valid = 1'b0;
    chk("busy_latency", lat, 15);
    chk("busy_digits", int'(digits_now()), 16'h0321);

    // Reset five shifts into a conversion.
    @(negedge clk);
    in_valid = 1'b1;
    bin      = 14'd5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_digits", int'(digits_now()), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_ready", int'(in_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    dcount  = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midreset_no_done", dcount, 0);
    chk("midreset_ready_after", int'(in_ready), 1);
    do_conv(14'd5678, dg, ov);
    chk("after_reset_digits", int'(dg), 16'h5678);

    for (int i = 0; i < 30; i++) begin
      int unsigned v;
      v = (i % 3 == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 9999);
      r = ref_model(v);
      do_conv(14'(v), dg, ov);
      chk("rand_digits", int'(dg), int'(r[15:0]));
      chk("rand_overflow", int'(ov), int'(r[16]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
